// File: rtl/parking_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_meter_pkg
//  Description : Shared types and constants for the coin accumulator: meter
//                state encoding, default per-channel coin values and a
//                coin-value lookup helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_meter_pkg;

  // Meter states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } meter_state_t;

  // Up to eight coin channels, each value held in one byte
  localparam int MAX_COINS    = 8;
  localparam int COIN_VALUE_W = 8;
  localparam int COIN_IDX_W   = 3;

  // Channel 0 = 5, channel 1 = 10, channel 2 = 20, unused channels = 0
  localparam logic [MAX_COINS*COIN_VALUE_W-1:0] DEFAULT_COIN_VALUES =
    {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd10, 8'd5};

  // Pick the credit value of one channel out of the packed value table
  function automatic logic [COIN_VALUE_W-1:0] coin_value(
    input logic [MAX_COINS*COIN_VALUE_W-1:0] values,
    input logic [COIN_IDX_W-1:0]             idx
  );
    return values[{idx, 3'b000} +: COIN_VALUE_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : coin_edge_detect
//  Description : Samples the coin switches, detects rising edges, encodes the
//                lowest-index event and flags when more than one channel rose
//                in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_edge_detect
  import parking_meter_pkg::*;
#(
  parameter int NUM_COINS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_COINS-1:0]  sw_coin,
  output logic                  event_valid,
  output logic [COIN_IDX_W-1:0] event_idx,
  output logic                  collision
);

  logic [NUM_COINS-1:0] prev_sample;
  logic [NUM_COINS-1:0] rise;

  // Previous-cycle sample; reset loads ones so switches held through reset give no edge
  always_ff @(posedge clk) begin
    if (reset) prev_sample <= '1;
    else       prev_sample <= sw_coin;
  end

  assign rise = sw_coin & ~prev_sample;

  // Lowest-index rising channel wins; scan downward so the last hit is the lowest
  always_comb begin
    event_valid = 1'b0;
    event_idx   = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        event_valid = 1'b1;
        event_idx   = COIN_IDX_W'(i);
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something behind
  assign collision = (rise & (rise - NUM_COINS'(1))) != '0;

endmodule
`default_nettype wire

// File: rtl/coin_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : coin_accumulator
//  Description : Parking-meter credit accumulator. Coin edges add credit up to
//                a ceiling, sw_start meters the credit down on each tick, and
//                the meter expires when credit reaches zero.
//                Optional macro COIN_SATURATE_EN: an over-ceiling coin clamps
//                credit to MAX_TIME and is accepted instead of rejected.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_accumulator
  import parking_meter_pkg::*;
#(
  parameter int NUM_COINS = 3,
  parameter int TIME_W    = 8,
  parameter int MAX_TIME  = 99,
  parameter logic [MAX_COINS*COIN_VALUE_W-1:0] COIN_VALUES = DEFAULT_COIN_VALUES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] sw_coin,
  input  logic                 sw_start,
  input  logic                 tick,
  output logic [TIME_W-1:0]    time_out,
  output logic                 running,
  output logic                 expired,
  output logic                 coin_accept,
  output logic                 coin_reject
);

  // Ceiling in the widened arithmetic domain so the compare cannot wrap
  localparam logic [TIME_W:0] MAX_EXT = (TIME_W + 1)'(MAX_TIME);

  meter_state_t              state;
  meter_state_t              state_next;
  logic                      event_valid;
  logic [COIN_IDX_W-1:0]     event_idx;
  logic                      collision;
  logic [COIN_VALUE_W-1:0]   raw_value;
  logic [TIME_W:0]           value_ext;
  logic [TIME_W:0]           time_ext;
  logic [TIME_W:0]           coin_sum;
  logic [TIME_W:0]           time_next;
  logic [TIME_W:0]           time_ticked;
  logic                      accept_next;
  logic                      reject_next;
  logic                      unused_time_msb;

  coin_edge_detect #(
    .NUM_COINS (NUM_COINS)
  ) u_edge (
    .clk         (clk),
    .reset       (reset),
    .sw_coin     (sw_coin),
    .event_valid (event_valid),
    .event_idx   (event_idx),
    .collision   (collision)
  );

  assign raw_value = coin_value(COIN_VALUES, event_idx);
  assign value_ext = (TIME_W + 1)'(raw_value);
  assign time_ext  = {1'b0, time_out};
  assign coin_sum  = time_ext + value_ext;

  // Coin crediting, then state transitions and metering on the post-coin credit
  always_comb begin
    state_next  = state;
    time_next   = time_ext;
    time_ticked = time_ext;
    accept_next = 1'b0;
    reject_next = collision;

    // Acceptance is judged on the pre-tick credit
    if (event_valid) begin
      if (state == EXPIRED) begin
        reject_next = 1'b1;
      end else if (coin_sum <= MAX_EXT) begin
        accept_next = 1'b1;
        time_next   = coin_sum;
      end else begin
`ifdef COIN_SATURATE_EN
        accept_next = 1'b1;
        time_next   = MAX_EXT;
`else
        reject_next = 1'b1;
`endif
      end
    end

    case (state)
      IDLE: begin
        if (sw_start && (time_out != '0)) state_next = RUN;
      end
      RUN: begin
        // Pause wins over tick and keeps the remaining credit
        if (!sw_start) begin
          state_next = IDLE;
        end else if (tick) begin
          time_ticked = time_next - (TIME_W + 1)'(1);
          time_next   = time_ticked;
          // A coin landing on the final tick leaves credit above zero
          if (time_ticked == '0) state_next = EXPIRED;
        end
      end
      EXPIRED: begin
        time_next = '0;
        if (!sw_start) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        time_next  = '0;
      end
    endcase
  end

  // Credit never exceeds MAX_TIME, so the carry bit is always clear here
  assign unused_time_msb = time_next[TIME_W];

  // State, credit and one-cycle coin pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      time_out    <= '0;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_next;
      time_out    <= time_next[TIME_W-1:0];
      coin_accept <= accept_next;
      coin_reject <= reject_next;
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

endmodule
`default_nettype wire

// File: tb/tb_coin_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_accumulator
//  Description : Directed, table-driven bench for coin_accumulator plus a
//                hand-written switch-hold sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sw_coin = 3'b000;
  logic       sw_start = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] time_out;
  logic       running;
  logic       expired;
  logic       coin_accept;
  logic       coin_reject;

  int checks   = 0;
  int failures = 0;

`ifdef COIN_SATURATE_EN
  localparam logic [7:0] T_CEIL   = 8'd99;
  localparam logic       ACC_CEIL = 1'b1;
  localparam logic       REJ_CEIL = 1'b0;
`else
  localparam logic [7:0] T_CEIL   = 8'd90;
  localparam logic       ACC_CEIL = 1'b0;
  localparam logic       REJ_CEIL = 1'b1;
`endif

  coin_accumulator #(
    .NUM_COINS (3),
    .TIME_W    (8),
    .MAX_TIME  (99)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_coin     (sw_coin),
    .sw_start    (sw_start),
    .tick        (tick),
    .time_out    (time_out),
    .running     (running),
    .expired     (expired),
    .coin_accept (coin_accept),
    .coin_reject (coin_reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] coin;
    logic       start;
    logic       tk;
    logic [7:0] t;
    logic       run;
    logic       exp;
    logic       acc;
    logic       rej;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [2:0] coin, input logic start,
                     input logic tk, input logic [7:0] t, input logic run,
                     input logic exp, input logic acc, input logic rej,
                     input string name);
    vec_t v;
    v.rst = rst; v.coin = coin; v.start = start; v.tk = tk;
    v.t = t; v.run = run; v.exp = exp; v.acc = acc; v.rej = rej;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge
  task automatic step(input logic rst, input logic [2:0] coin,
                      input logic start, input logic tk);
    reset = rst; sw_coin = coin; sw_start = start; tick = tk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_count;

    //   rst coin    st tk  t     run exp acc rej  name
    add(1, 3'b000, 0, 0, 8'd0,  0, 0, 0, 0, "reset");
    add(0, 3'b000, 0, 0, 8'd0,  0, 0, 0, 0, "idle_after_reset");
    add(0, 3'b001, 0, 0, 8'd5,  0, 0, 1, 0, "ch0_credit");
    add(0, 3'b000, 0, 0, 8'd5,  0, 0, 0, 0, "ch0_release");
    add(0, 3'b010, 0, 0, 8'd15, 0, 0, 1, 0, "ch1_credit");
    add(0, 3'b000, 0, 0, 8'd15, 0, 0, 0, 0, "ch1_release");
    add(0, 3'b100, 0, 0, 8'd35, 0, 0, 1, 0, "ch2_credit");
    add(0, 3'b000, 0, 0, 8'd35, 0, 0, 0, 0, "ch2_release");
    add(0, 3'b010, 0, 0, 8'd45, 0, 0, 1, 0, "hold_first");
    add(0, 3'b010, 0, 0, 8'd45, 0, 0, 0, 0, "hold_no_recredit_a");
    add(0, 3'b010, 0, 0, 8'd45, 0, 0, 0, 0, "hold_no_recredit_b");
    add(0, 3'b000, 0, 0, 8'd45, 0, 0, 0, 0, "hold_release");
    add(0, 3'b100, 0, 0, 8'd65, 0, 0, 1, 0, "fill_65");
    add(0, 3'b000, 0, 0, 8'd65, 0, 0, 0, 0, "fill_65_rel");
    add(0, 3'b100, 0, 0, 8'd85, 0, 0, 1, 0, "fill_85");
    add(0, 3'b000, 0, 0, 8'd85, 0, 0, 0, 0, "fill_85_rel");
    add(0, 3'b001, 0, 0, 8'd90, 0, 0, 1, 0, "fill_90");
    add(0, 3'b000, 0, 0, 8'd90, 0, 0, 0, 0, "fill_90_rel");
    add(0, 3'b010, 0, 0, T_CEIL, 0, 0, ACC_CEIL, REJ_CEIL, "ceiling_coin");
    add(0, 3'b000, 0, 0, T_CEIL, 0, 0, 0, 0, "ceiling_rel");
    // Metering down to expiry
    add(1, 3'b000, 0, 0, 8'd0,  0, 0, 0, 0, "reset2");
    add(0, 3'b000, 1, 0, 8'd0,  0, 0, 0, 0, "start_zero_stays_idle");
    add(0, 3'b001, 0, 0, 8'd5,  0, 0, 1, 0, "credit5");
    add(0, 3'b000, 1, 0, 8'd5,  1, 0, 0, 0, "start_run");
    add(0, 3'b000, 1, 1, 8'd4,  1, 0, 0, 0, "tick_4");
    add(0, 3'b000, 1, 1, 8'd3,  1, 0, 0, 0, "tick_3");
    add(0, 3'b000, 1, 1, 8'd2,  1, 0, 0, 0, "tick_2");
    add(0, 3'b000, 0, 1, 8'd2,  0, 0, 0, 0, "pause_beats_tick");
    add(0, 3'b000, 1, 0, 8'd2,  1, 0, 0, 0, "resume");
    add(0, 3'b000, 1, 1, 8'd1,  1, 0, 0, 0, "tick_1");
    add(0, 3'b000, 1, 1, 8'd0,  0, 1, 0, 0, "tick_expire");
    add(0, 3'b001, 1, 0, 8'd0,  0, 1, 0, 1, "expired_reject");
    add(0, 3'b000, 1, 1, 8'd0,  0, 1, 0, 0, "expired_hold");
    add(0, 3'b000, 0, 0, 8'd0,  0, 0, 0, 0, "expired_to_idle");
    // Coin on the final tick keeps the meter running
    add(0, 3'b001, 0, 0, 8'd5,  0, 0, 1, 0, "c5");
    add(0, 3'b000, 1, 0, 8'd5,  1, 0, 0, 0, "run5");
    add(0, 3'b000, 1, 1, 8'd4,  1, 0, 0, 0, "r4");
    add(0, 3'b000, 1, 1, 8'd3,  1, 0, 0, 0, "r3");
    add(0, 3'b000, 1, 1, 8'd2,  1, 0, 0, 0, "r2");
    add(0, 3'b000, 1, 1, 8'd1,  1, 0, 0, 0, "r1");
    add(0, 3'b001, 1, 1, 8'd5,  1, 0, 1, 0, "coin_on_last_tick");
    add(0, 3'b000, 1, 0, 8'd5,  1, 0, 0, 0, "still_running");
    add(0, 3'b100, 1, 1, 8'd24, 1, 0, 1, 0, "coin_plus_tick");
    add(0, 3'b000, 0, 0, 8'd24, 0, 0, 0, 0, "pause24");
    // Simultaneous channels and reset-held switches
    add(1, 3'b000, 0, 0, 8'd0,  0, 0, 0, 0, "reset3");
    add(0, 3'b000, 0, 0, 8'd0,  0, 0, 0, 0, "idle3");
    add(0, 3'b101, 0, 0, 8'd5,  0, 0, 1, 1, "collision_0_2");
    add(0, 3'b000, 0, 0, 8'd5,  0, 0, 0, 0, "collision_rel");
    add(1, 3'b010, 0, 0, 8'd0,  0, 0, 0, 0, "reset_held_sw");
    add(0, 3'b010, 0, 0, 8'd0,  0, 0, 0, 0, "held_through_reset");
    add(0, 3'b000, 0, 0, 8'd0,  0, 0, 0, 0, "held_release");
    add(0, 3'b010, 0, 0, 8'd10, 0, 0, 1, 0, "fresh_edge");
    // Reset in the middle of RUN
    add(0, 3'b000, 1, 0, 8'd10, 1, 0, 0, 0, "run10");
    add(0, 3'b000, 1, 1, 8'd9,  1, 0, 0, 0, "run9");
    add(1, 3'b000, 1, 1, 8'd0,  0, 0, 0, 0, "reset_mid_run");
    add(0, 3'b000, 1, 1, 8'd0,  0, 0, 0, 0, "after_reset_no_expire");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].coin, vecs[i].start, vecs[i].tk);
      check({vecs[i].name, ".time_out"}, int'(time_out),    int'(vecs[i].t));
      check({vecs[i].name, ".running"},  int'(running),     int'(vecs[i].run));
      check({vecs[i].name, ".expired"},  int'(expired),     int'(vecs[i].exp));
      check({vecs[i].name, ".accept"},   int'(coin_accept), int'(vecs[i].acc));
      check({vecs[i].name, ".reject"},   int'(coin_reject), int'(vecs[i].rej));
    end

    // Hold channel 1 for ten cycles: one credit, one accept pulse
    step(1, 3'b000, 0, 0);
    step(0, 3'b000, 0, 0);
    acc_count = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 3'b010, 0, 0);
      if (coin_accept) acc_count++;
    end
    step(0, 3'b000, 0, 0);
    check("hold10.accept_count", acc_count, 1);
    check("hold10.time_out", int'(time_out), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
